sha256_msg_feeder: RTL and testbench

Host-side driver for the sha256_module compression core. Accepts a byte stream, applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length), packs 512-bit blocks in the core's word order, and sequences core reset/start/done across all blocks of one message. Captures the final chained digest and presents it with a one-cycle valid pulse. Sits between the software/data-path byte source and sha256_module in the goldminer hash path.

---
 rtl/sha256_pkg.sv | 35 +++
 rtl/sha256_block_packer.sv | 51 +++++
 rtl/sha256_msg_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
//------------------------------------------------------------------------------
// Module   : sha256_pkg
// Purpose  : Shared constants and FSM encoding for the SHA-256 message feeder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
    localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
    localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
    localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
    localparam logic [31:0] SHA256_H4 = 32'h510e527f;
    localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
    localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
    localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PAD   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_CAPT  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sha256_block_packer.sv
//------------------------------------------------------------------------------
// Module   : sha256_block_packer
// Purpose  : 512-bit block buffer with byte write, clear and length insert.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256_block_packer
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_wr_en,
    input  logic [5:0]         i_wr_idx,
    input  logic [7:0]         i_wr_byte,
    input  logic               i_len_en,
    input  logic [63:0]        i_bit_len,
    output logic [BLOCK_W-1:0] o_block
);

    logic [BLOCK_W-1:0] r_block;
    logic [BLOCK_W-1:0] w_next;
    logic [8:0]         w_ofs;

    // Word idx/4 sits at bit 32*word; byte 0 of a word is its most significant lane.
    assign w_ofs = {i_wr_idx[5:2], 5'd0} + {4'd0, ~i_wr_idx[1:0], 3'd0};

    always_comb begin
        w_next = i_clear ? '0 : r_block;
        if (i_wr_en) begin
            w_next[w_ofs +: 8] = i_wr_byte;
        end
        if (i_len_en) begin
            w_next[511:448] = {i_bit_len[31:0], i_bit_len[63:32]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_block <= '0;
        end else begin
            r_block <= w_next;
        end
    end

    assign o_block = r_block;

endmodule

`default_nettype wire

// File: rtl/sha256_msg_feeder.sv
//------------------------------------------------------------------------------
// Module   : sha256_msg_feeder
// Purpose  : Pads a byte stream into SHA-256 blocks and sequences the core.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha256_msg_feeder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic                core_reset,
    output logic                core_start,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic                core_done,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [LEN_W-1:0]     r_byte_cnt;
    logic [6:0]           r_blk_cnt;
    logic                 r_final;
    logic                 r_pad_pending;
    logic                 r_trailer_80;
    logic                 r_core_rst_pulse;
    logic [DIGEST_W-1:0]  r_digest;
    logic                 r_digest_valid;

    logic                 w_hs;
    logic                 w_pk_clear;
    logic                 w_pk_wr;
    logic [5:0]           w_pk_idx;
    logic [7:0]           w_pk_byte;
    logic                 w_pk_len;
    logic [63:0]          w_bit_len;

    assign w_hs      = s_valid & s_ready;
    assign w_bit_len = 64'(r_byte_cnt) << 3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_state_nxt = s_last ? ST_PAD : ST_FILL;
                end
            end
            ST_FILL: begin
                if (s_valid) begin
                    if (s_last) begin
                        w_state_nxt = ST_PAD;
                    end else if (r_blk_cnt == 7'd63) begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_PAD:   w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    w_state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (r_final) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_pad_pending) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        core_start = 1'b0;
        w_pk_clear = 1'b0;
        w_pk_wr    = 1'b0;
        w_pk_idx   = 6'd0;
        w_pk_byte  = s_data;
        w_pk_len   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_ready    = 1'b1;
                w_pk_clear = s_valid;
                w_pk_wr    = s_valid;
            end
            ST_FILL: begin
                s_ready  = 1'b1;
                w_pk_wr  = s_valid;
                w_pk_idx = r_blk_cnt[5:0];
            end
            ST_PAD: begin
                // A completely full block goes out untouched; its 0x80 lands in the trailer.
                w_pk_wr   = (r_blk_cnt != 7'd64);
                w_pk_idx  = r_blk_cnt[5:0];
                w_pk_byte = PAD_BYTE;
                w_pk_len  = (r_blk_cnt <= 7'd55);
            end
            ST_ISSUE: core_start = 1'b1;
            ST_CAPT: begin
                w_pk_clear = 1'b1;
                if (!r_final && r_pad_pending) begin
                    w_pk_len  = 1'b1;
                    w_pk_wr   = r_trailer_80;
                    w_pk_byte = PAD_BYTE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt       <= '0;
            r_blk_cnt        <= '0;
            r_final          <= 1'b0;
            r_pad_pending    <= 1'b0;
            r_trailer_80     <= 1'b0;
            r_core_rst_pulse <= 1'b0;
            r_digest         <= '0;
            r_digest_valid   <= 1'b0;
        end else begin
            r_core_rst_pulse <= 1'b0;
            r_digest_valid   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_byte_cnt       <= LEN_W'(1);
                        r_blk_cnt        <= 7'd1;
                        r_final          <= 1'b0;
                        r_pad_pending    <= 1'b0;
                        r_trailer_80     <= 1'b0;
                        r_core_rst_pulse <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_hs) begin
                        if (r_byte_cnt != '1) begin
                            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                        end
                        r_blk_cnt <= r_blk_cnt + 7'd1;
                    end
                end
                ST_PAD: begin
                    if (r_blk_cnt <= 7'd55) begin
                        r_final <= 1'b1;
                    end else begin
                        r_pad_pending <= 1'b1;
                        r_trailer_80  <= (r_blk_cnt == 7'd64);
                    end
                end
                ST_CAPT: begin
                    if (r_final) begin
                        r_digest       <= core_digest;
                        r_digest_valid <= 1'b1;
                    end else if (r_pad_pending) begin
                        r_final       <= 1'b1;
                        r_pad_pending <= 1'b0;
                    end else begin
                        r_blk_cnt <= 7'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    sha256_block_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_pk_clear),
        .i_wr_en   (w_pk_wr),
        .i_wr_idx  (w_pk_idx),
        .i_wr_byte (w_pk_byte),
        .i_len_en  (w_pk_len),
        .i_bit_len (w_bit_len),
        .o_block   (core_block)
    );

    // The core is held in reset alongside us so an aborted message leaves nothing behind.
    assign core_reset   = reset | r_core_rst_pulse;
    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;
    assign busy         = (r_state != ST_IDLE) | r_digest_valid;

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_feeder.sv
//------------------------------------------------------------------------------
// Module   : tb_sha256_msg_feeder
// Purpose  : Directed bench for sha256_msg_feeder with a behavioural SHA-256 core.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sha256_msg_feeder;
    import sha256_pkg::*;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_56 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic         core_reset;
    logic         core_start;
    logic [511:0] core_block;
    logic         core_done;
    logic [255:0] core_digest;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    always #5 clk = ~clk;

    sha256_msg_feeder #(.LEN_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .core_reset   (core_reset),
        .core_start   (core_start),
        .core_block   (core_block),
        .core_done    (core_done),
        .core_digest  (core_digest),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = w[t-16] + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Behavioural core: fixed latency, digest chains until core_reset.
    logic [255:0] m_h;
    logic [511:0] m_blk;
    int           m_cnt;

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_reset) begin
            m_h         <= {SHA256_H0, SHA256_H1, SHA256_H2, SHA256_H3,
                            SHA256_H4, SHA256_H5, SHA256_H6, SHA256_H7};
            m_cnt       <= 0;
            core_digest <= '0;
        end else if (core_start) begin
            m_blk <= core_block;
            m_cnt <= 5;
        end else if (m_cnt == 1) begin
            m_h         <= compress(m_h, m_blk);
            core_digest <= compress(m_h, m_blk);
            core_done   <= 1'b1;
            m_cnt       <= 0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end
    end

    // Observation on the falling edge.
    int           start_cnt = 0;
    int           rst_cnt   = 0;
    int           dv_cnt    = 0;
    int           rdy_viol  = 0;
    int           blk_chg   = 0;
    logic         busy_at_dv = 1'b0;
    logic         inflt     = 1'b0;
    logic         in_capt   = 1'b0;
    logic [511:0] held_blk  = '0;
    logic [511:0] blk_q [$];
    logic [255:0] dig_q [$];

    always @(negedge clk) begin
        if (reset) begin
            inflt   = 1'b0;
            in_capt = 1'b0;
        end else begin
            if (core_reset) rst_cnt++;
            if (digest_valid) begin
                dv_cnt++;
                dig_q.push_back(digest);
                busy_at_dv = busy;
            end
            if (core_start) begin
                start_cnt++;
                blk_q.push_back(core_block);
                inflt    = 1'b1;
                held_blk = core_block;
            end
            if (inflt) begin
                if (s_ready) rdy_viol++;
                if (core_block !== held_blk) blk_chg++;
            end
            if (in_capt) begin
                inflt   = 1'b0;
                in_capt = 1'b0;
            end else if (inflt && core_done) begin
                in_capt = 1'b1;
            end
        end
    end

    logic [7:0] msg [64];

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
    endtask

    task automatic send(input int len, input int gap_max);
        logic ok;
        int   budget;
        for (int i = 0; i < len; i++) begin
            if (gap_max > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) @(posedge clk);
                #1;
            end
            s_data  = msg[i];
            s_valid = 1'b1;
            s_last  = (i == len - 1);
            budget  = 0;
            do begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk);
                budget++;
            end while (!ok && budget < 200);
            #1;
            if (!ok) begin
                chk("handshake_timeout", 1'b1, 1'b0);
                i = len;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_dv(input int target);
        int t = 0;
        while (dv_cnt < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("digest_valid_seen", 256'(dv_cnt >= target), 256'd1);
    endtask

    int b0, r0, d0, gap_viol0, gap_chg0;

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 256'(s_ready), 256'd1);
        chk("rst_core_reset", 256'(core_reset), 256'd1);
        chk("rst_core_start", 256'(core_start), 256'd0);
        chk("rst_core_block", core_block[255:0] | core_block[511:256], 256'd0);
        chk("rst_digest", digest, 256'd0);
        chk("rst_digest_valid", 256'(digest_valid), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // "abc": single block
        load_str("abc");
        b0 = start_cnt; r0 = rst_cnt; d0 = dv_cnt;
        send(3, 0);
        wait_dv(d0 + 1);
        chk("abc_digest", digest, DIG_ABC);
        chk("abc_starts", 256'(start_cnt - b0), 256'd1);
        chk("abc_core_resets", 256'(rst_cnt - r0), 256'd1);
        chk("abc_word0", 256'(blk_q[b0][31:0]), 256'h61626380);
        chk("abc_word15", 256'(blk_q[b0][511:480]), 256'h00000018);
        chk("abc_busy_at_dv", 256'(busy_at_dv), 256'd1);
        repeat (2) @(negedge clk);
        chk("abc_busy_after", 256'(busy), 256'd0);
        @(posedge clk); #1;

        // 56-byte message: 0x80 fills byte 56, trailer block carries the length
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        b0 = start_cnt; r0 = rst_cnt; d0 = dv_cnt;
        send(56, 0);
        wait_dv(d0 + 1);
        chk("m56_digest", digest, DIG_56);
        chk("m56_starts", 256'(start_cnt - b0), 256'd2);
        chk("m56_core_resets", 256'(rst_cnt - r0), 256'd1);
        chk("m56_blk1_word14", 256'(blk_q[b0][479:448]), 256'h80000000);
        chk("m56_blk2_words0_13", 256'(blk_q[b0+1][447:0]), 256'd0);
        chk("m56_blk2_word15", 256'(blk_q[b0+1][511:480]), 256'h000001c0);
        @(posedge clk); #1;

        // 64 x 'a': exactly full block, trailer starts with 0x80
        for (int i = 0; i < 64; i++) msg[i] = 8'h61;
        b0 = start_cnt; d0 = dv_cnt;
        send(64, 0);
        wait_dv(d0 + 1);
        chk("m64_starts", 256'(start_cnt - b0), 256'd2);
        chk("m64_blk1_lo", blk_q[b0][255:0], {8{32'h61616161}});
        chk("m64_blk1_hi", blk_q[b0][511:256], {8{32'h61616161}});
        chk("m64_blk2_word0", 256'(blk_q[b0+1][31:0]), 256'h80000000);
        chk("m64_blk2_mid", 256'(blk_q[b0+1][479:32]), 256'd0);
        chk("m64_blk2_word15", 256'(blk_q[b0+1][511:480]), 256'h00000200);
        @(posedge clk); #1;

        // "abc" with random s_valid gaps
        load_str("abc");
        d0 = dv_cnt; gap_viol0 = rdy_viol; gap_chg0 = blk_chg;
        send(3, 3);
        wait_dv(d0 + 1);
        chk("gap_digest", digest, DIG_ABC);
        chk("gap_ready_low_in_flight", 256'(rdy_viol - gap_viol0), 256'd0);
        chk("gap_block_stable", 256'(blk_chg - gap_chg0), 256'd0);
        @(posedge clk); #1;

        // Reset while block 1 of a 2-block message is in the core
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        b0 = start_cnt; d0 = dv_cnt;
        send(56, 0);
        for (int t = 0; t < 100 && start_cnt == b0; t++) @(negedge clk);
        chk("abort_block1_started", 256'(start_cnt - b0), 256'd1);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy_cleared", 256'(busy), 256'd0);
        chk("abort_no_dv", 256'(dv_cnt - d0), 256'd0);
        @(posedge clk); #1;
        load_str("abc");
        r0 = rst_cnt;
        send(3, 0);
        wait_dv(d0 + 1);
        repeat (10) @(negedge clk);
        chk("abort_dv_count", 256'(dv_cnt - d0), 256'd1);
        chk("abort_abc_digest", dig_q[d0], DIG_ABC);
        chk("abort_core_resets", 256'(rst_cnt - r0), 256'd1);
        @(posedge clk); #1;

        // Back-to-back "abc" messages
        r0 = rst_cnt; d0 = dv_cnt;
        send(3, 0);
        send(3, 0);
        wait_dv(d0 + 2);
        chk("b2b_dv_count", 256'(dv_cnt - d0), 256'd2);
        chk("b2b_digest0", dig_q[d0], DIG_ABC);
        chk("b2b_digest1", dig_q[d0+1], DIG_ABC);
        chk("b2b_core_resets", 256'(rst_cnt - r0), 256'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
